lfsr_run_ctrl: RTL
==================

// Module: lfsr_run_ctrl
// PURPOSE
//  Run controller for the 22-bit XNOR LFSR (lfsr_22bit) feeding the sequence detector.
//  Reseeds the LFSR, drives its shift enable in free-run or single-step mode, and counts shifts until the LFSR's max_tick reports a completed cycle.
//  Also counts sequence-detector hits during the run and flags whether the measured period equals the expected maximal length.
// PARAMETERS
//  CNT_W    23       width of shift counter
//  EXP_LEN  4194303  expected period, 2^22-1
//  TIMEOUT  4194400  shift count at which a run is force-ended (must be > EXP_LEN)
//  HIT_W    16       width of hit counter
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      pulse: begin a run (honoured only in IDLE)
//  abort      in   1      end the current run immediately (RUN only)
//  step_mode  in   1      1 = shift only on step, 0 = shift every cycle
//  step       in   1      single-shift request (used when step_mode=1)
//  max_tick   in   1      LFSR max_tick_reg
//  det_hit    in   1      sequence-detector match pulse
//  lfsr_rst   out  1      to LFSR rst_n pin (active-high sync seed load)
//  sh_en      out  1      to LFSR sh_en
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse on DONE
//  timeout    out  1      last run ended on TIMEOUT
//  aborted    out  1      last run ended on abort
//  period_ok  out  1      last run ended on max_tick with cycle_cnt==EXP_LEN
//  cycle_cnt  out  CNT_W  shifts issued in current/last run
//  hit_cnt    out  HIT_W  det_hit count in current/last run
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE. All outputs and counters are 0.
//  FSM states: IDLE=0, SEED=1, RUN=2, DONE=3.
//  IDLE: lfsr_rst=0, sh_en=0. start=1 -> SEED. Results from the last run are held.
//  SEED (1 cycle): lfsr_rst=1. Clears cycle_cnt, hit_cnt, timeout, aborted, period_ok. Goes to RUN.
//  RUN: sh_en is a combinational decode:
//   sh_en = RUN & ~abort & ~end_tick & ~(cycle_cnt==TIMEOUT) & (~step_mode | step)
//   end_tick = max_tick & (cycle_cnt != 0). max_tick is ignored while cycle_cnt==0, because it is stale from the pre-seed state.
//   Each sh_en=1 cycle: cycle_cnt+1 at the clock edge.
//   hit_cnt+1 on det_hit & sh_en, saturating at all-ones.
//  RUN exits (priority high to low, evaluated the same cycle):
//   1. abort -> IDLE, aborted=1, no done pulse.
//   2. end_tick -> DONE, period_ok=(cycle_cnt==EXP_LEN).
//   3. cycle_cnt==TIMEOUT -> DONE, timeout=1.
//   The exiting cycle issues no shift, so cycle_cnt is final.
//  DONE (1 cycle): done=1, then IDLE.
//  start outside IDLE is ignored. step in free-run mode is ignored.
//  step_mode may change mid-RUN and takes effect the same cycle.
//  Real LFSR timing: after the seed load, max_tick rises in the cycle after the 4194303rd shift edge, so cycle_cnt=4194303 and period_ok=1.
//  rst_n low mid-RUN: outputs go to 0 at once and the LFSR is not reseeded. The next start reseeds it via SEED.
//  cycle_cnt never wraps, since TIMEOUT < 2^CNT_W.
//  All outputs except sh_en are registered.
// TESTING
//  T1 reset: rst_n=0 mid-RUN -> same cycle state=0, sh_en=0, busy=0, cycle_cnt=0.
//  T2 stub max_tick: start @c0 -> lfsr_rst=1 @c1, sh_en=1 c2..c11, max_tick=1 @c12 -> done @c13, cycle_cnt=10, period_ok=0.
//  T3 with lfsr_22bit: free run -> done, cycle_cnt=4194303, period_ok=1, timeout=0.
//  T4 TIMEOUT=100, max_tick=0 -> done, cycle_cnt=100, timeout=1. abort at shift 50 -> IDLE next cycle, aborted=1, cycle_cnt=50, no done.
//  T5 step_mode=1, 3 step pulses, det_hit on 2 of them -> cycle_cnt=3, hit_cnt=2. max_tick=1 at cycle_cnt=0 is ignored.
//  T6 HIT_W=2, det_hit held high for 10 shifts -> hit_cnt=3 (saturated). start during RUN -> no effect.

Source files
------------

// File: rtl/lfsr_run_ctrl.sv
// Run controller for the 22-bit XNOR LFSR: seeds it, gates its shift enable,
// measures the period up to max_tick and counts detector hits over the run.
module lfsr_run_ctrl #(
  parameter int unsigned CNT_W   = 23,
  parameter int unsigned EXP_LEN = 4194303,
  parameter int unsigned TIMEOUT = 4194400,
  parameter int unsigned HIT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  input  logic             max_tick,
  input  logic             det_hit,
  output logic             lfsr_rst,
  output logic             sh_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             aborted,
  output logic             period_ok,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_LEN);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  state_t state;
  logic   end_tick;
  logic   at_timeout;

  // max_tick is stale from the pre-seed LFSR state until the first shift lands
  always_comb begin
    end_tick   = max_tick & (cycle_cnt != '0);
    at_timeout = (cycle_cnt == TO_CNT);
    sh_en      = (state == RUN) & ~abort & ~end_tick & ~at_timeout & (~step_mode | step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr_rst  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
      period_ok <= 1'b0;
      cycle_cnt <= '0;
      hit_cnt   <= '0;
    end else begin
      done     <= 1'b0;
      lfsr_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SEED;
            lfsr_rst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEED: begin
          state     <= RUN;
          cycle_cnt <= '0;
          hit_cnt   <= '0;
          timeout   <= 1'b0;
          aborted   <= 1'b0;
          period_ok <= 1'b0;
        end
        RUN: begin
          if (sh_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (det_hit && (hit_cnt != '1))
              hit_cnt <= hit_cnt + HIT_W'(1);
          end
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (end_tick) begin
            state     <= DONE;
            done      <= 1'b1;
            period_ok <= (cycle_cnt == EXP_CNT);
          end else if (at_timeout) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
